// File: rtl/pe_array_pkg.sv
// Shared encodings and constants for the bit-serial PE array sequencer.
package pe_array_pkg;
  localparam int PE_NCOL     = 32;
  localparam int PE_NPE      = 128;
  localparam int MAX_BITCOLS = 8;

  typedef enum logic [1:0] {
    ACC_HOLD = 2'b00,
    ACC_CLR  = 2'b01,
    ACC_ACC  = 2'b10
  } acc_e;

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD_ACT, STREAM_WT, WAIT_DONE, DRAIN
  } state_e;

  function automatic logic cfg_ok(input logic k_nz, input logic [3:0] bitcols);
    return k_nz && (bitcols != 4'd0) && (bitcols <= 4'(MAX_BITCOLS));
  endfunction
endpackage

// File: rtl/pe_array_ctrl_if.sv
// Control-side bundle between tile scheduler, operand buffers, PE array and result sink.
interface pe_array_ctrl_if #(
  parameter int K_W  = 16,
  parameter int NCOL = 32,
  parameter int NPE  = 128
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [K_W-1:0]  cmd_k_steps;
  logic [3:0]      cmd_bitcols;
  logic            act_req;
  logic            act_gnt;
  logic            wt_req;
  logic            wt_gnt;
  logic            activation_valid;
  logic            weight_valid;
  logic            weight_sign_en;
  logic [1:0]      acc_en;
  logic [NCOL-1:0] zcip_done;
  logic [NPE-1:0]  pe_done;
  logic            res_valid;
  logic            res_ready;
  logic            busy;
  logic            err_cfg;
  logic            err_timeout;

  modport master (
    input  cmd_valid, cmd_k_steps, cmd_bitcols, act_gnt, wt_gnt, pe_done, res_ready,
    output cmd_ready, act_req, wt_req, activation_valid, weight_valid, weight_sign_en,
           acc_en, zcip_done, res_valid, busy, err_cfg, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_k_steps, cmd_bitcols, act_gnt, wt_gnt, pe_done, res_ready,
    input  cmd_ready, act_req, wt_req, activation_valid, weight_valid, weight_sign_en,
           acc_en, zcip_done, res_valid, busy, err_cfg, err_timeout
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// Tile sequencer: clear, then per K step one activation block and bitcols weight beats,
// wait for all PEs, hand the result off. Array-side strobes are registered one cycle behind grants.
module pe_array_ctrl import pe_array_pkg::*; #(
  parameter int K_W     = 16,
  parameter int NCOL    = PE_NCOL,
  parameter int NPE     = PE_NPE,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  pe_array_ctrl_if.master bus
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state, state_nxt;
  logic [K_W-1:0]  k_steps, step_cnt;
  logic [3:0]      bitcols, bit_cnt;
  logic [TW-1:0]   timer;
  logic            accept, cfg_bad, beat, last_beat, last_step, all_done, expired;
  acc_e            acc_q;
  logic            act_v_q, wt_v_q, sign_q, cmd_ready_q, err_cfg_q, err_tmo_q;

  assign accept    = (state == IDLE) && cmd_ready_q && bus.cmd_valid;
  assign cfg_bad   = !cfg_ok(|bus.cmd_k_steps, bus.cmd_bitcols);
  assign beat      = (state == STREAM_WT) && bus.wt_gnt;
  assign last_beat = beat && (bit_cnt == bitcols - 4'd1);
  assign last_step = (step_cnt == k_steps - K_W'(1));
  assign all_done  = &bus.pe_done;
  assign expired   = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept && !cfg_bad) state_nxt = CLEAR;
      CLEAR:     state_nxt = LOAD_ACT;
      LOAD_ACT:  if (bus.act_gnt) state_nxt = STREAM_WT;
      STREAM_WT: if (last_beat) state_nxt = last_step ? WAIT_DONE : LOAD_ACT;
      WAIT_DONE: if (all_done || expired) state_nxt = DRAIN;
      DRAIN:     if (bus.res_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Requests and result handshake follow the current state directly.
  always_comb begin
    bus.act_req   = 1'b0;
    bus.wt_req    = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.act_req   = (state == LOAD_ACT);
    bus.wt_req    = (state == STREAM_WT);
    bus.res_valid = (state == DRAIN);
    bus.busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_steps     <= '0;
      bitcols     <= '0;
      step_cnt    <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      cmd_ready_q <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      acc_q       <= ACC_HOLD;
      act_v_q     <= 1'b0;
      wt_v_q      <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      cmd_ready_q <= (state_nxt == IDLE);
      act_v_q     <= (state == LOAD_ACT) && bus.act_gnt;
      wt_v_q      <= beat;
      sign_q      <= last_beat;
      acc_q       <= (state == CLEAR) ? ACC_CLR : (beat ? ACC_ACC : ACC_HOLD);
      if (accept) begin
        k_steps <= bus.cmd_k_steps;
        bitcols <= bus.cmd_bitcols;
        if (cfg_bad) err_cfg_q <= 1'b1;
      end
      if (state == CLEAR) step_cnt <= '0;
      if ((state == LOAD_ACT) && bus.act_gnt) bit_cnt <= '0;
      if (beat) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (last_beat && !last_step) step_cnt <= step_cnt + K_W'(1);
      end
      // Completion on the expiry cycle takes priority over the timeout flag.
      timer <= (state == WAIT_DONE) ? timer + TW'(1) : '0;
      if ((state == WAIT_DONE) && expired && !all_done) err_tmo_q <= 1'b1;
    end
  end

  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.activation_valid = act_v_q;
  assign bus.weight_valid     = wt_v_q;
  assign bus.weight_sign_en   = sign_q;
  assign bus.acc_en           = acc_q;
  assign bus.zcip_done        = {NCOL{sign_q}};
  assign bus.err_cfg          = err_cfg_q;
  assign bus.err_timeout      = err_tmo_q;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: table of tile commands plus reset-mid-stream sequence,
// with a one-cycle-latency scoreboard on the array-side strobes.
module tb_pe_array_ctrl;
  import pe_array_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_array_ctrl_if #(.K_W(16), .NCOL(PE_NCOL), .NPE(PE_NPE)) bus ();

  pe_array_ctrl #(.K_W(16), .NCOL(PE_NCOL), .NPE(PE_NPE), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic       act;
    logic       wv;
    logic       sign;
    logic [1:0] acc;
  } exp_t;

  typedef struct {
    int k;
    int bc;
    int gmode;     // 0 grants high, 1 wt_gnt toggles, 2 random
    int done_dly;  // ticks after last grant before pe_done all ones; -1 never
    int rr_dly;    // cycles of res_ready low while res_valid
    bit cfg_bad;
    bit tmo;
    int beats;
    int signs;
    int acts;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[8];
  int   checks = 0;
  int   failures = 0;
  int   cur_bc, beat_i, beats_left, ticks_since;
  int   n_wv, n_sign, n_act, n_clr;
  bit   clr_arm = 1'b0;
  bit   accept_now = 1'b0;
  bit   last_done = 1'b0;
  bit   cfg_sticky = 1'b0;
  bit   tmo_sticky = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Predict next-cycle strobes from this cycle's requests and grants, then clock and compare.
  task automatic step();
    exp_t e;
    e = '0;
    if (!rst) begin
      if (clr_arm) e.acc = ACC_CLR;
      if (bus.act_req && bus.act_gnt) begin
        e.act  = 1'b1;
        beat_i = 0;
      end
      if (bus.wt_req && bus.wt_gnt) begin
        e.wv   = 1'b1;
        e.acc  = ACC_ACC;
        e.sign = (beat_i == cur_bc - 1);
        beat_i++;
        beats_left--;
        if (beats_left == 0) last_done = 1'b1;
      end
      clr_arm = accept_now;
    end else begin
      clr_arm = 1'b0;
    end
    accept_now = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("array_strobes", 64'({bus.activation_valid, bus.weight_valid, bus.weight_sign_en, bus.acc_en}), 64'(e));
    chk("zcip_done", 64'(bus.zcip_done), 64'({PE_NCOL{e.sign}}));
    chk("req_exclusive", 64'(bus.act_req & bus.wt_req), 64'(0));
    n_wv   += int'(bus.weight_valid);
    n_sign += int'(bus.weight_sign_en);
    n_act  += int'(bus.activation_valid);
    n_clr  += int'(bus.acc_en == ACC_CLR);
    if (last_done) ticks_since++;
  endtask

  task automatic run_tile(input vec_t v, input string tag);
    int  wait_n;
    bit  seen_res;
    n_wv = 0; n_sign = 0; n_act = 0; n_clr = 0;
    cur_bc = v.bc; beat_i = 0; beats_left = v.k * v.bc;
    last_done = 1'b0; ticks_since = 0;
    bus.act_gnt = 1'b0; bus.wt_gnt = 1'b0; bus.res_ready = 1'b0;
    wait_n = 0;
    while (!bus.cmd_ready && wait_n < 20) begin
      step();
      wait_n++;
    end
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid   = 1'b1;
    bus.cmd_k_steps = 16'(v.k);
    bus.cmd_bitcols = 4'(v.bc);
    accept_now = !v.cfg_bad;
    step();
    bus.cmd_valid = 1'b0;
    if (v.cfg_bad) begin
      cfg_sticky = 1'b1;
      for (int i = 0; i < 3; i++) begin
        chk({tag, "_stays_idle"}, 64'({bus.busy, bus.cmd_ready, bus.act_req, bus.wt_req}), 64'(4'b0100));
        step();
      end
      chk({tag, "_err_cfg"}, 64'(bus.err_cfg), 64'(1));
      chk({tag, "_no_activity"}, 64'(n_wv + n_act + n_clr), 64'(0));
      return;
    end
    chk({tag, "_busy"}, 64'({bus.busy, bus.cmd_ready}), 64'(2'b10));
    seen_res = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_res; cyc++) begin
      case (v.gmode)
        0: begin bus.act_gnt = 1'b1; bus.wt_gnt = 1'b1; end
        1: begin bus.act_gnt = 1'b1; bus.wt_gnt = cyc[0]; end
        default: begin
          bus.act_gnt = 1'($urandom_range(1));
          bus.wt_gnt  = 1'($urandom_range(1));
        end
      endcase
      bus.pe_done = (last_done && v.done_dly >= 0 && ticks_since >= v.done_dly)
                    ? {PE_NPE{1'b1}} : {{(PE_NPE-1){1'b1}}, 1'b0};
      step();
      if (last_done && ticks_since == 1)
        chk({tag, "_req_drop"}, 64'({bus.act_req, bus.wt_req}), 64'(0));
      if (v.done_dly < 0 || v.done_dly == TO) begin
        if (ticks_since == TO)
          chk({tag, "_pre_expiry"}, 64'({bus.res_valid, bus.err_timeout}), 64'(0));
        if (ticks_since == TO + 1)
          chk({tag, "_expiry"}, 64'({bus.res_valid, bus.err_timeout}), 64'({1'b1, v.tmo}));
      end
      seen_res = bus.res_valid;
    end
    chk({tag, "_res_valid_seen"}, 64'(seen_res), 64'(1));
    bus.act_gnt = 1'b0; bus.wt_gnt = 1'b0;
    for (int i = 0; i < v.rr_dly; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_k_steps = 16'd1;
      bus.cmd_bitcols = 4'd1;
      step();
      chk({tag, "_backpressure"}, 64'({bus.res_valid, bus.cmd_ready, bus.busy}), 64'(3'b101));
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    tmo_sticky |= v.tmo;
    chk({tag, "_handoff"}, 64'({bus.res_valid, bus.busy, bus.cmd_ready, bus.err_cfg, bus.err_timeout}),
        64'({1'b0, 1'b0, 1'b1, cfg_sticky, tmo_sticky}));
    chk({tag, "_beats"}, 64'(n_wv), 64'(v.beats));
    chk({tag, "_signs"}, 64'(n_sign), 64'(v.signs));
    chk({tag, "_acts"}, 64'(n_act), 64'(v.acts));
    chk({tag, "_clears"}, 64'(n_clr), 64'(1));
  endtask

  initial begin
    //           k  bc gm dly rr cfg tmo beats signs acts
    tbl[0] = '{2, 3, 0,  5,  0, 1'b0, 1'b0,  6, 2, 2};  // nominal
    tbl[1] = '{1, 8, 1,  3,  0, 1'b0, 1'b0,  8, 1, 1};  // grant stalls
    tbl[2] = '{1, 2, 0, TO,  0, 1'b0, 1'b0,  2, 1, 1};  // done on expiry cycle
    tbl[3] = '{2, 1, 2,  2, 10, 1'b0, 1'b0,  2, 2, 2};  // bitcols=1, backpressure
    tbl[4] = '{1, 9, 0,  0,  0, 1'b1, 1'b0,  0, 0, 0};  // bitcols > 8
    tbl[5] = '{0, 3, 0,  0,  0, 1'b1, 1'b0,  0, 0, 0};  // k_steps = 0
    tbl[6] = '{1, 4, 0, -1,  0, 1'b0, 1'b1,  4, 1, 1};  // timeout
    tbl[7] = '{3, 5, 2,  0,  2, 1'b0, 1'b0, 15, 3, 3};  // fresh tile after reset

    bus.cmd_valid = 1'b0; bus.cmd_k_steps = '0; bus.cmd_bitcols = '0;
    bus.act_gnt = 1'b0; bus.wt_gnt = 1'b0; bus.pe_done = '0; bus.res_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset_state", 64'({bus.cmd_ready, bus.busy, bus.act_req, bus.wt_req, bus.res_valid,
                            bus.err_cfg, bus.err_timeout}), 64'(0));
    rst = 1'b0;
    step();
    chk("reset_release_ready", 64'({bus.cmd_ready, bus.busy}), 64'(2'b10));

    for (int i = 0; i < 7; i++) run_tile(tbl[i], $sformatf("vec%0d", i));

    // Reset lands on the edge that would register the third weight beat.
    cur_bc = 3; beat_i = 0; beats_left = 6; last_done = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_k_steps = 16'd2; bus.cmd_bitcols = 4'd3;
    accept_now = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.act_gnt = 1'b1; bus.wt_gnt = 1'b1;
    for (int i = 0; i < 20 && beats_left > 4; i++) step();
    chk("midstream_two_beats", 64'(beats_left), 64'(4));
    chk("midstream_wt_req", 64'(bus.wt_req), 64'(1));
    rst = 1'b1;
    step();
    chk("midstream_reset_vals", 64'({bus.cmd_ready, bus.busy, bus.act_req, bus.wt_req, bus.res_valid,
                                     bus.err_cfg, bus.err_timeout}), 64'(0));
    rst = 1'b0;
    bus.act_gnt = 1'b0; bus.wt_gnt = 1'b0;
    cfg_sticky = 1'b0; tmo_sticky = 1'b0;
    step();
    chk("midstream_ready_again", 64'({bus.cmd_ready, bus.busy}), 64'(2'b10));
    run_tile(tbl[7], "replay");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Sequencer for the 4x32 bit-serial PE array.
- Accepts one tile command and clears the accumulators.
- For each K step, loads an activation block, then streams one weight bit-column per beat with the correct acc_en, weight_sign_en and zcip_done.
- Waits for all 128 PE done flags, then hands the tile result off downstream. Sits between the tile scheduler and the activation/weight buffers and the PE array.
- The activation, weight, shift and result data buses bypass this block; it drives only control.

Parameters:
- K_W, 16, width of the K-step count field.
- NCOL, 32, PE columns (zcip_done width).
- NPE, 128, PE count (pe_done width).
- TIMEOUT, 1024, maximum cycles spent in WAIT_DONE before an error is flagged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  tile command valid
- cmd_ready  out  1  controller can accept a command
- cmd_k_steps  in  K_W  activation blocks per tile; legal 1..2^K_W-1
- cmd_bitcols  in  4  weight bit-columns per K step; legal 1..8
- act_req  out  1  request next activation block from buffer
- act_gnt  in  1  buffer presents the block this cycle
- wt_req  out  1  request next weight bit-column
- wt_gnt  in  1  buffer presents the bit-column this cycle
- activation_valid  out  1  to array
- weight_valid  out  1  to array
- weight_sign_en  out  1  to array; marks the sign (last) bit-column
- acc_en  out  2  to array; 00 hold, 01 clear, 10 accumulate, 11 reserved (never driven)
- zcip_done  out  NCOL  to array; per-column end of K step
- pe_done  in  NPE  done flags from array
- res_valid  out  1  tile result ready in array
- res_ready  in  1  downstream has consumed the result
- busy  out  1  state != IDLE
- err_cfg  out  1  sticky: illegal command field seen
- err_timeout  out  1  sticky: WAIT_DONE expired

Behaviour:
- Reset values: cmd_ready=0, all array-side outputs 0, acc_en=00, res_valid=0, busy=0, err flags=0, FSM=IDLE. The next cycle cmd_ready=1.
- Array-side outputs (activation_valid, weight_valid, weight_sign_en, acc_en, zcip_done) are registered. Each pulse appears exactly 1 cycle after the grant/state that caused it, aligned with buffer data delayed by one flop. acc_en defaults to 00 whenever not explicitly driven.
- FSM states: IDLE, CLEAR, LOAD_ACT, STREAM_WT, WAIT_DONE, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the fields.
  - If k_steps==0, bitcols==0 or bitcols>8: set err_cfg and stay IDLE. No array activity; the command is consumed.
  - Otherwise go to CLEAR.
- CLEAR: acc_en=01 for exactly one cycle; step_cnt=0; go to LOAD_ACT.
- LOAD_ACT:
  - act_req=1 until act_gnt.
  - On act_gnt: activation_valid pulses once, bit_cnt=0, go to STREAM_WT.
- STREAM_WT:
  - wt_req=1.
  - Each wt_gnt beat: weight_valid=1 and acc_en=10. weight_sign_en=1 only when bit_cnt==bitcols-1. zcip_done is all ones only on that same beat, otherwise 0. bit_cnt++.
  - Gaps without a grant produce no pulses and acc_en=00.
  - After the last beat of a step: if step_cnt==k_steps-1, go to WAIT_DONE; else step_cnt++ and go to LOAD_ACT. wt_req deasserts in the cycle after the last grant.
- WAIT_DONE:
  - Timer counts from 0.
  - When all pe_done are set (AND-reduce), go to DRAIN.
  - When the timer reaches TIMEOUT-1 without that, set err_timeout and go to DRAIN.
  - If done and expiry coincide, done wins: no error.
- DRAIN:
  - res_valid=1, held until res_ready; it must not drop without res_ready.
  - On res_ready, go to IDLE; cmd_ready returns next cycle.
- Ordering: act_req and wt_req are never asserted together. A grant without a matching request is ignored.
- Bitcols=1: every beat is a sign beat (weight_sign_en and zcip_done on each).
- Counters: step_cnt is K_W bits and bit_cnt is 4 bits; neither wraps within a legal command.
- Reset mid-operation: immediate return to the reset values. No partial res_valid; sticky errors clear.
- Sticky errors clear only on rst.

Decomposition:
- Shared package (pe_array_pkg) holds:
  - the acc_en encodings (ACC_HOLD, ACC_CLR, ACC_ACC)
  - the FSM state enum
  - the NCOL/NPE constants
  - the max bitcols constant (8)
- Single module; no sub-module needed. The WAIT_DONE timer is inline.

Test Plan:
- Nominal tile:
  - Stimulus: cmd k_steps=2, bitcols=3; grants always high; pe_done all ones 5 cycles after the last beat; res_ready=1.
  - Response: one acc_en=01 pulse; 2 activation_valid pulses; 6 weight_valid beats with acc_en=10; weight_sign_en and zcip_done=0xFFFFFFFF on beats 3 and 6 only; one res_valid; busy drops after it.
- Grant stalls:
  - Stimulus: k_steps=1, bitcols=8; wt_gnt toggles every other cycle.
  - Response: exactly 8 weight_valid pulses, each 1 cycle after a grant; acc_en=00 in the gap cycles; sign on the 8th only.
- Illegal commands:
  - Stimulus: bitcols=9, then k_steps=0.
  - Response: err_cfg=1; no act_req or wt_req; cmd_ready stays 1; the FSM remains IDLE.
- Timeout:
  - Stimulus: TIMEOUT=16; one PE done bit held 0.
  - Response: err_timeout set 16 cycles after entering WAIT_DONE; res_valid asserts.
  - Boundary: done arriving on cycle 16 gives no error.
- Backpressure:
  - Stimulus: res_ready low for 10 cycles.
  - Response: res_valid stays 1 for all 10; cmd_ready stays 0; a new cmd_valid is not accepted until 1 cycle after res_ready.
- Reset mid-stream:
  - Stimulus: rst during the 3rd weight beat.
  - Response: the next cycle shows all outputs at reset values; a fresh command replays from CLEAR.
